uart_tx: RTL
============

# uart_tx

Byte-serial UART transmitter, the transmit-side counterpart of the `rx` pattern-detect receive path. It accepts one byte per valid/ready handshake and drives an 8N1 frame on `tx`: start bit low, 8 data bits LSB first, stop bit high. It also emits per-bit and end-of-frame strobes so the existing receive chain can be driven in loopback benches and on the board.

## Interface
- `CLK_FREQ_HZ`, default 1_600_000: system clock frequency in Hz.
- `BAUD_RATE`, default 100_000: line rate in bit/s.
  - CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE, using integer division with truncation; 16 at the defaults.
  - An elaboration check requires CLKS_PER_BIT >= 2.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_valid` in 1: byte offered on `tx_data`.
- `tx_data` in 8: byte to send; sampled only on handshake.
- `tx_ready` out 1: block can accept a byte.
- `tx` out 1: serial line, registered, idle high.
- `busy` out 1: a frame is in progress, from the start bit through the stop bit.
- `bit_strobe` out 1: one-cycle pulse in the first cycle of every bit period.
- `frame_done` out 1: one-cycle pulse when the stop bit completes.

## Operation
- **States:** IDLE, START, DATA, PARITY (present only with the macro), STOP.
- **Handshake:**
  - A transfer occurs on an edge where `tx_valid && tx_ready`.
  - `tx_data` is copied into an 8-bit shift register on that edge.
  - Later changes to `tx_data` or `tx_valid` have no effect until the next handshake.
- **`tx_ready`:** registered; equals 1 only in IDLE and 0 in every other state.
- **Baud counter:**
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - When it reaches CLKS_PER_BIT-1, the bit period ends.
- **Transitions at the end of each bit period:**
  - IDLE -> START on handshake.
  - START -> DATA.
  - DATA stays in DATA until 8 bits have been sent. A 3-bit index counts 0..7; each period shifts the register right and `tx` = bit[index].
  - DATA -> PARITY, or -> STOP when parity is compiled out.
  - PARITY -> STOP.
  - STOP -> IDLE.
- **Line values by state:** IDLE 1, START 0, DATA data bit, PARITY parity bit, STOP 1.
- **`busy`:** 1 in START through STOP.
- **`bit_strobe`:**
  - Asserted in the same cycle that `tx` first shows a new bit.
  - 10 pulses per frame, or 11 with parity.
- **`frame_done`:** asserted in the first IDLE cycle after STOP, the same cycle `tx_ready` returns to 1.
- **Reset:**
  - Reset dominates everything, including mid-frame.
  - Next cycle: `tx`=1, `tx_ready`=0, `busy`=0, `bit_strobe`=0, `frame_done`=0, state IDLE, counters 0.
  - `tx_ready` rises in the first cycle after `rst` falls.
  - An aborted frame is not resumed and produces no `frame_done`.

## Timing
- **Handshake and start bit:**
  - Handshake on edge k; state is START from cycle k+1.
  - `tx`=0 and `bit_strobe`=1 in cycle k+1.
- **Data bits:** bit n (0..7) occupies cycles k+1+(n+1)·CPB through k+(n+2)·CPB, where CPB = CLKS_PER_BIT.
- **Stop bit:** occupies cycles k+1+9·CPB through k+10·CPB.
- **End of frame:** `frame_done`=1 and `tx_ready`=1 in cycle k+1+10·CPB.
- **Frame length at defaults:** 161 cycles per 8N1 frame including the single idle/ready cycle; 177 cycles with parity.
- **Back-to-back frames:**
  - If `tx_valid` is held high, the next handshake occurs on the edge ending the `frame_done` cycle.
  - That gives exactly one idle-high cycle between stop bit and next start bit.
- **Simultaneous events:** `rst` and a handshake in the same cycle: reset wins and the byte is dropped.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - The PARITY state is compiled in.
  - One even-parity bit (XOR of the 8 data bits) is sent between D7 and stop.
  - Frame is 11 bits; `bit_strobe` gives 11 pulses.
- **Not defined:**
  - The PARITY state, its logic and its encoding are absent.
  - Frame is 10 bits (8N1).
- The receiver must be built with a matching setting; the transmitter does no checking.

## Structure
- **Shared package `uart_pkg`:**
  - State enum `uart_tx_state_t`.
  - `DATA_BITS` = 8.
  - Function `clks_per_bit(clk_hz, baud)` returning the integer division result.
  - Both transmit and receive paths use the package.
- **Sub-module `tx_baud_ctr`:**
  - Synchronous active-high clear.
  - Outputs the `bit_end` pulse at CLKS_PER_BIT-1.
  - Parameterized by CLKS_PER_BIT.
- FSM, shift register, index counter and output registers live in `uart_tx`.

## Test plan
- **Single byte:** send 0xA5 at default parameters -> `tx` per-bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. Also check 10 `bit_strobe` pulses, `frame_done` at handshake+161, and `busy` low afterwards.
- **Back-to-back bytes:** `tx_valid` held high with 0x00 then 0xFF -> exactly one idle-high cycle between frames. The second frame's data bits are all 1; `tx_ready` is high for exactly one cycle between frames.
- **Input stability:** change `tx_data` from 0x3C to 0xC3 two cycles after the handshake -> the line carries 0x3C unchanged.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 3 -> next cycle `tx`=1, `busy`=0, `tx_ready`=0. Also check no `frame_done`, `tx_ready`=1 one cycle after release, and a new 0x55 frame is correct.
- **Parity (with `UART_TX_PARITY_EN`):** send 0x07 -> parity bit 1; send 0x03 -> parity bit 0. Frame is 177 cycles with 11 strobes.
- **Non-integer divide:** CLK_FREQ_HZ=1_000_000, BAUD_RATE=300_000 -> CLKS_PER_BIT=3, each bit 3 cycles. Looped into the existing receiver (`rx`) at its own matching parameters, 0x06 raises `match`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the transmit and receive paths.
// UART_TX_PARITY_EN adds the PARITY state to the transmit FSM.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte valid/ready handshake into the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );

endinterface

// File: rtl/tx_baud_ctr.sv
// Bit-period counter; bit_end marks the last cycle of each period.
module tx_baud_ctr #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic clr,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with per-bit and end-of-frame strobes.
// Define UART_TX_PARITY_EN for an even-parity bit between D7 and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 1_600_000,
    parameter int BAUD_RATE   = 100_000
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     busy,
    output logic     bit_strobe,
    output logic     frame_done
);

    localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    generate
        if (CPB < 2) begin : g_cpb_chk
            $error("uart_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 strobe_q, strobe_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic bit_end;
    logic ctr_clr;
    logic handshake;

    // IDLE holds the counter at zero, so START always gets a full period.
    assign ctr_clr   = rst || (state_q == ST_IDLE);
    assign handshake = bus.tx_valid && ready_q;

    tx_baud_ctr #(
        .CLKS_PER_BIT(CPB)
    ) u_baud (
        .clk     (clk),
        .clr     (ctr_clr),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (handshake) begin
                    state_d  = ST_START;
                    shreg_d  = bus.tx_data;
                    idx_d    = '0;
                    tx_d     = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    strobe_d = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.tx_data;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d  = ST_DATA;
                    tx_d     = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    strobe_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    strobe_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d  = ST_STOP;
                    tx_d     = 1'b1;
                    strobe_d = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.tx_ready = ready_q;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign bit_strobe   = strobe_q;
    assign frame_done   = done_q;

endmodule
